// File: rtl/serial_complement_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// serial_complement_ctrl_pkg
// Shared definitions for the serial complement controller:
//   state_t   : controller FSM states (IDLE / SHIFT / DONE)
//   MODE_ONES : in_mode value selecting ones' complement
//   MODE_TWOS : in_mode value selecting two's complement
// ---------------------------------------------------------------------------
package serial_complement_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ONES = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

endpackage

// File: rtl/serial_complement_ctrl_cell.sv
// ---------------------------------------------------------------------------
// serial_compl_cell
// One-bit serial complement cell, fed LSB-first.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset
//   bit_i    : operand bit for this cycle
//   mode_i   : MODE_ONES / MODE_TWOS
//   clear_i  : clears the carry flag (start of a new operand)
//   enable_i : a bit is being consumed this cycle
//   bit_o    : complemented bit (combinational)
// ---------------------------------------------------------------------------
import serial_complement_ctrl_pkg::*;

module serial_compl_cell (
  input  logic clk,
  input  logic reset,
  input  logic bit_i,
  input  logic mode_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic bit_o
);

  logic flag_q;
  logic flag_d;

  // Two's complement = copy bits up to and including the first 1, then
  // invert the rest; the flag remembers that the first 1 has gone past.
  always_comb begin
    flag_d = flag_q;
    if (clear_i) begin
      flag_d = 1'b0;
    end else if (enable_i && (mode_i == MODE_TWOS) && bit_i) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= 1'b0;
    end else begin
      flag_q <= flag_d;
    end
  end

  assign bit_o = (mode_i == MODE_TWOS) ? (bit_i ^ flag_q) : ~bit_i;

endmodule

// File: rtl/serial_complement_ctrl.sv
// ---------------------------------------------------------------------------
// serial_complement_ctrl
// Accepts a WIDTH-bit operand over a valid/ready handshake, complements it
// one bit per clock (LSB first) and presents the result over a second
// valid/ready handshake.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low reset
//   in_valid  : operand offered           in_ready  : operand can be taken
//   in_data   : operand                   in_mode   : 0 ones', 1 two's
//   out_valid : result available          out_ready : consumer takes result
//   out_data  : complemented result       busy      : SHIFT or DONE
//   out_ovf   : two's complement of the most negative value (only when
//               COMPL_OVF_EN is defined)
// Optional feature macro: COMPL_OVF_EN
// ---------------------------------------------------------------------------
import serial_complement_ctrl_pkg::*;

module serial_complement_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef COMPL_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] result_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;

  logic acceptEn;
  logic shiftEn;
  logic releaseEn;
  logic cellBit;

  // in_ready is held low while reset is asserted so nothing looks acceptable
  // until the block is actually running.
  assign in_ready  = reset && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SHIFT) || (state_q == DONE);
  assign out_data  = result_q;

  assign acceptEn  = in_valid && in_ready;
  assign shiftEn   = (state_q == SHIFT);
  assign releaseEn = out_valid && out_ready;

  serial_compl_cell u_cell (
    .clk      (clk),
    .reset    (reset),
    .bit_i    (data_q[0]),
    .mode_i   (mode_q),
    .clear_i  (acceptEn),
    .enable_i (shiftEn),
    .bit_o    (cellBit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (acceptEn) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    if (releaseEn) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand shifts out of the bottom while result bits enter at the top, so
  // after WIDTH shifts the first processed bit has reached result_q[0].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q   <= '0;
      result_q <= '0;
      mode_q   <= MODE_ONES;
      cnt_q    <= '0;
    end else if (acceptEn) begin
      data_q <= in_data;
      mode_q <= in_mode;
      cnt_q  <= '0;
    end else if (shiftEn) begin
      data_q   <= data_q >> 1;
      result_q <= {cellBit, result_q[WIDTH-1:1]};
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

`ifdef COMPL_OVF_EN
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic ovf_q;

  // Decided at capture time since the operand is consumed by the shift.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (acceptEn) begin
      ovf_q <= (in_mode == MODE_TWOS) && (in_data == MIN_NEG);
    end else if (releaseEn) begin
      ovf_q <= 1'b0;
    end
  end

  assign out_ovf = ovf_q && (state_q == DONE);
`endif

endmodule

// File: tb/tb_serial_complement_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_complement_ctrl
// Directed testbench for serial_complement_ctrl with WIDTH=8. Works with or
// without COMPL_OVF_EN; overflow checks are included only when it is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_complement_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_mode = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic             busy;
  logic [WIDTH-1:0] out_data;
`ifdef COMPL_OVF_EN
  logic             out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  int n;
  int seen;
  int acc;
  int del;
  int cyc;
  int lastAcc;
  logic wasAcc;
  logic wasDel;
  logic [WIDTH-1:0] bData [3];
  logic             bMode [3];
  logic [WIDTH-1:0] bExp  [3];

  serial_complement_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef COMPL_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop in case some wait escapes its bound
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic m);
    in_valid = v;
    in_data  = d;
    in_mode  = m;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full transaction: accept, scramble inputs, measure latency, check, release
  task automatic runOp(input string tag, input logic [WIDTH-1:0] d, input logic m,
                       input logic [WIDTH-1:0] expData, input logic expOvf);
    int k;
    k = 0;
    while (!in_ready && k < 20) begin
      tick();
      k++;
    end
    checkOutput({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b1, d, m);
    tick();
    applyStimulus(1'b0, ~d, ~m);
    checkOutput({tag, " busy"}, {31'd0, busy}, 32'd1);
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    checkOutput({tag, " latency"}, k, 32'd8);
    checkOutput({tag, " data"}, {24'd0, out_data}, {24'd0, expData});
    checkOutput({tag, " in_ready done"}, {31'd0, in_ready}, 32'd0);
`ifdef COMPL_OVF_EN
    checkOutput({tag, " ovf"}, {31'd0, out_ovf}, {31'd0, expOvf});
`else
    if (expOvf) begin
    end
`endif
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, " released"}, {31'd0, out_valid}, 32'd0);
`ifdef COMPL_OVF_EN
    checkOutput({tag, " ovf cleared"}, {31'd0, out_ovf}, 32'd0);
`endif
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b0, '0, 1'b0);
    #12;
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset out_data", {24'd0, out_data}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd0);
`ifdef COMPL_OVF_EN
    checkOutput("reset ovf", {31'd0, out_ovf}, 32'd0);
`endif
    reset = 1'b1;
    tick();
    checkOutput("post reset in_ready", {31'd0, in_ready}, 32'd1);

    // Basic function
    runOp("twos 05", 8'h05, 1'b1, 8'hFB, 1'b0);
    runOp("ones 5A", 8'h5A, 1'b0, 8'hA5, 1'b0);
    runOp("twos 00", 8'h00, 1'b1, 8'h00, 1'b0);
    runOp("twos 80", 8'h80, 1'b1, 8'h80, 1'b1);
    runOp("twos 7F", 8'h7F, 1'b1, 8'h81, 1'b0);
    runOp("ones 80", 8'h80, 1'b0, 8'h7F, 1'b0);

    // Stall in DONE with in_valid pulses that must be ignored
    applyStimulus(1'b1, 8'hC3, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("hold latency", n, 32'd8);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(k[0], 8'(k * 17 + 1), 1'b1);
      tick();
      checkOutput("hold out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("hold out_data", {24'd0, out_data}, 32'h3C);
      checkOutput("hold in_ready", {31'd0, in_ready}, 32'd0);
    end
    applyStimulus(1'b0, '0, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("hold released", {31'd0, out_valid}, 32'd0);
    checkOutput("hold busy", {31'd0, busy}, 32'd0);

    // Reset during SHIFT at bit 3
    applyStimulus(1'b1, 8'h33, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("mid busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid reset busy", {31'd0, busy}, 32'd0);
    checkOutput("mid reset out_data", {24'd0, out_data}, 32'd0);
    checkOutput("mid reset in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    reset = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (out_valid) seen++;
    end
    checkOutput("after reset no out_valid", seen, 32'd0);
    runOp("twos 01", 8'h01, 1'b1, 8'hFF, 1'b0);

    // Back-to-back with out_ready held high
    bData[0] = 8'h01; bMode[0] = 1'b1; bExp[0] = 8'hFF;
    bData[1] = 8'h5A; bMode[1] = 1'b0; bExp[1] = 8'hA5;
    bData[2] = 8'h10; bMode[2] = 1'b1; bExp[2] = 8'hF0;
    acc = 0;
    del = 0;
    cyc = 0;
    lastAcc = 0;
    out_ready = 1'b1;
    applyStimulus(1'b1, bData[0], bMode[0]);
    while (del < 3 && cyc < 60) begin
      wasAcc = in_valid && in_ready;
      wasDel = out_valid && out_ready;
      if (wasDel) begin
        if (del < 3) checkOutput($sformatf("b2b result %0d", del), {24'd0, out_data}, {24'd0, bExp[del]});
        del++;
      end
      tick();
      cyc++;
      if (wasAcc) begin
        if (acc > 0) checkOutput("b2b spacing", cyc - lastAcc, 32'd10);
        lastAcc = cyc;
        acc++;
        if (acc < 3) applyStimulus(1'b1, bData[acc], bMode[acc]);
        else applyStimulus(1'b0, '0, 1'b0);
      end
    end
    out_ready = 1'b0;
    checkOutput("b2b accepts", acc, 32'd3);
    checkOutput("b2b deliveries", del, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
